// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbitrated K-to-1 datapath mux.
package mux_pkg;

  localparam int DEF_K     = 4;
  localparam int DEF_SIZE  = 16;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Counter width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Plain K-to-1 mux over a flattened bus; requester i occupies bits [i*SIZE +: SIZE].
module Mux_k_to_1 #(
  parameter int K    = 4,
  parameter int SIZE = 16
) (
  input  logic [$clog2(K)-1:0] i_sel,
  input  logic [K*SIZE-1:0]    i_bus,
  output logic [SIZE-1:0]      o_data
);

  logic [SIZE-1:0] w_slices [K];

  for (genvar gi = 0; gi < K; gi++) begin : g_slice
    assign w_slices[gi] = i_bus[gi*SIZE +: SIZE];
  end

  assign o_data = w_slices[i_sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a K-to-1 datapath mux; an owner keeps the mux for
// up to BURST beats, then the next requester after it wins.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int SIZE  = DEF_SIZE,
  parameter int BURST = DEF_BURST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [K-1:0]         req,
  input  logic [K*SIZE-1:0]    in_bus,
  output logic [K-1:0]         ack,
  output logic [K-1:0]         grant,
  output logic [$clog2(K)-1:0] sel,
  output logic [SIZE-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int SW = $clog2(K);
  localparam int BW = clog2_min1(BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_sel, w_sel_next;
  logic [SW-1:0]   r_last, w_last_next;
  logic [BW-1:0]   r_beat, w_beat_next;

  logic            w_busy;
  logic            w_xfer;
  logic            w_release;
  logic [SW-1:0]   w_base;
  logic            w_win_found;
  logic [SW-1:0]   w_win_idx;

  assign w_busy    = (r_state == ST_GRANT);
  assign out_valid = w_busy & req[r_sel];
  assign w_xfer    = out_valid & out_ready;
  assign grant     = w_busy ? (K'(1) << r_sel) : '0;
  assign ack       = w_xfer ? grant : '0;
  assign busy      = w_busy;
  assign sel       = r_sel;

  // A dropped request releases without a beat, so no ack is produced for it.
  assign w_release = w_busy & (~req[r_sel] | (w_xfer & (r_beat == LAST_BEAT)));

  // Searching from base+1 up to base+K puts the current owner last in line.
  assign w_base = w_busy ? r_sel : r_last;

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_last;
    for (int k = K; k >= 1; k--) begin
      if (req[(int'(w_base) + k) % K]) begin
        w_win_found = 1'b1;
        w_win_idx   = SW'((int'(w_base) + k) % K);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_last_next  = r_last;
    w_beat_next  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_next = ST_GRANT;
          w_sel_next   = w_win_idx;
          w_last_next  = w_win_idx;
          w_beat_next  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_beat_next = '0;
          if (w_win_found) begin
            w_sel_next  = w_win_idx;
            w_last_next = w_win_idx;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (w_xfer) begin
          w_beat_next = r_beat + BW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= SW'(K - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_last  <= w_last_next;
      r_beat  <= w_beat_next;
    end
  end

  Mux_k_to_1 #(
    .K    (K),
    .SIZE (SIZE)
  ) u_mux (
    .i_sel  (r_sel),
    .i_bus  (in_bus),
    .o_data (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter (BURST=4 and BURST=1 instances)
// against an owner/beat-count reference model.
module tb_mux_rr_arbiter;

  localparam int K    = 4;
  localparam int SIZE = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [K-1:0]         req;
  logic [K*SIZE-1:0]    in_bus;
  logic                 out_ready;

  logic [K-1:0]         ack_a, grant_a, ack_b, grant_b;
  logic [1:0]           sel_a, sel_b;
  logic [SIZE-1:0]      data_a, data_b;
  logic                 valid_a, valid_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  int m_owner [2];
  int m_beats [2];
  int m_last  [2];
  int m_burst [2] = '{4, 1};

  always #5 clk = ~clk;

  mux_rr_arbiter #(.K(K), .SIZE(SIZE), .BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .in_bus(in_bus), .ack(ack_a),
    .grant(grant_a), .sel(sel_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(out_ready), .busy(busy_a)
  );

  mux_rr_arbiter #(.K(K), .SIZE(SIZE), .BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .in_bus(in_bus), .ack(ack_b),
    .grant(grant_b), .sel(sel_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(out_ready), .busy(busy_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from);
    for (int k = 1; k <= K; k++)
      if (req[(from + k) % K]) return (from + k) % K;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_beats[d] = 0;
      m_last[d]  = K - 1;
    end
  endtask

  task automatic check_dut(input int d);
    logic [K-1:0]    e_grant, e_ack, a_grant, a_ack;
    logic            e_valid, a_valid, a_busy;
    logic [1:0]      a_sel;
    logic [SIZE-1:0] a_data;
    string           p;
    int              o;
    p       = (d == 0) ? "a" : "b";
    a_grant = (d == 0) ? grant_a : grant_b;
    a_ack   = (d == 0) ? ack_a   : ack_b;
    a_valid = (d == 0) ? valid_a : valid_b;
    a_busy  = (d == 0) ? busy_a  : busy_b;
    a_sel   = (d == 0) ? sel_a   : sel_b;
    a_data  = (d == 0) ? data_a  : data_b;
    o = m_owner[d];
    if (o < 0) begin
      e_grant = '0; e_valid = 1'b0; e_ack = '0;
    end else begin
      e_grant = K'(1) << o;
      e_valid = req[o];
      e_ack   = (e_valid && out_ready) ? e_grant : '0;
    end
    check_val({p, "_grant"}, 64'(a_grant), 64'(e_grant));
    check_val({p, "_valid"}, 64'(a_valid), 64'(e_valid));
    check_val({p, "_ack"},   64'(a_ack),   64'(e_ack));
    check_val({p, "_busy"},  64'(a_busy),  64'(o >= 0));
    if (o >= 0) begin
      check_val({p, "_sel"},  64'(a_sel),  64'(o));
      check_val({p, "_data"}, 64'(a_data), 64'(in_bus[o*SIZE +: SIZE]));
    end
  endtask

  task automatic model_edge(input int d);
    int  o, w;
    bit  xfer;
    o = m_owner[d];
    if (o < 0) begin
      w = rr_pick(m_last[d]);
      if (w >= 0) begin
        m_owner[d] = w; m_last[d] = w; m_beats[d] = 0;
      end
    end else begin
      xfer = req[o] && out_ready;
      if (xfer) m_beats[d]++;
      if ((xfer && m_beats[d] == m_burst[d]) || !req[o]) begin
        w = rr_pick(o);
        m_owner[d] = w;
        m_beats[d] = 0;
        if (w >= 0) m_last[d] = w;
      end
    end
  endtask

  task automatic step(input logic [K-1:0] r, input logic rdy, input bit rand_data);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    if (rand_data) in_bus = {$urandom, $urandom};
    #1;
    check_dut(0);
    check_dut(1);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_grant", 64'(grant_a), 64'(0));
    check_val("rst_sel",   64'(sel_a),   64'(0));
    check_val("rst_valid", 64'(valid_a), 64'(0));
    check_val("rst_busy",  64'(busy_a),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [K-1:0] r;
    logic [SIZE-1:0] held;
    rst_n = 1'b0; req = '0; out_ready = 1'b0; in_bus = '0;
    model_reset();

    // Scenario 1: lone requester 2 gets back-to-back bursts.
    do_reset();
    in_bus = '0;
    in_bus[2*SIZE +: SIZE] = 16'hA5A5;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      if (i > 0) begin
        check_val("s1_ack",  64'(ack_a),  64'(4'b0100));
        check_val("s1_data", 64'(data_a), 64'(16'hA5A5));
      end
    end

    // Scenarios 2 and 6: all requesting (BURST=4) and alternating pair (BURST=1).
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(4'b1111, 1'b1, 1'b1);
      if (i > 0) check_val("s2_ack", 64'(ack_a), 64'(K'(1) << (((i - 1) / 4) % 4)));
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b0101, 1'b1, 1'b1);
      if (i > 0) check_val("s6_ack", 64'(ack_b), 64'(((i - 1) % 2) ? 4'b0100 : 4'b0001));
    end

    // Scenario 3: backpressure on owner 1 holds everything.
    do_reset();
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0010, 1'b1, 1'b0);
    held = data_a;
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      check_val("s3_data", 64'(data_a), 64'(held));
      check_val("s3_ack",  64'(ack_a),  64'(0));
    end
    for (int i = 0; i < 6; i++) step(4'b0010, 1'b1, 1'b1);

    // Scenario 4: owner 0 drops after 2 beats, requester 3 takes over.
    do_reset();
    step(4'b1001, 1'b1, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b1);
    check_val("s4_drop_ack", 64'(ack_a), 64'(0));
    step(4'b1000, 1'b1, 1'b1);
    check_val("s4_grant", 64'(grant_a), 64'(4'b1000));

    // Scenario 5: asynchronous reset mid-burst.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("s5_grant", 64'(grant_a), 64'(0));
    check_val("s5_valid", 64'(valid_a), 64'(0));
    check_val("s5_ack",   64'(ack_a),   64'(0));
    check_val("s5_busy",  64'(busy_a),  64'(0));
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    check_val("s5_first", 64'(grant_a), 64'(4'b0001));

    // Random traffic against the reference model.
    do_reset();
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < K; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(3) != 0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
